multicycle_controller: RTL

//   Moore FSM sequencing a multicycle MIPS datapath (shared memory, IR, ALU, PC) over multiple cycles per instruction.

---
 rtl/multicycle_controller.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle MIPS datapath: sequences fetch, decode and per-class
// execute/memory/writeback states and drives every datapath select and write enable.
module multicycle_controller #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic [2:0] alu_ctrl,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t     state_r;
    state_t     next_state_s;
    logic       iord_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_dst_s;
    logic       mem_to_reg_s;
    logic       reg_write_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] pc_src_s;
    logic       pc_write_s;
    logic       branch_s;
    logic [1:0] alu_op_s;

    function automatic logic [2:0] alu_decode(input logic [1:0] alu_op, input logic [5:0] fn);
        logic [2:0] ctrl;
        case (alu_op)
            2'b00: ctrl = 3'b010;
            2'b01: ctrl = 3'b110;
            2'b10: begin
                case (fn)
                    6'b100000: ctrl = 3'b010;
                    6'b100010: ctrl = 3'b110;
                    6'b100100: ctrl = 3'b000;
                    6'b100101: ctrl = 3'b001;
                    6'b101010: ctrl = 3'b111;
                    default:   ctrl = 3'b010;
                endcase
            end
            default: ctrl = 3'b010;
        endcase
        return ctrl;
    endfunction

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        next_state_s = S_FETCH;
        iord_s       = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        pc_src_s     = 2'b00;
        pc_write_s   = 1'b0;
        branch_s     = 1'b0;
        alu_op_s     = 2'b00;
        case (state_r)
            S_FETCH: begin
                ir_write_s   = 1'b1;
                alu_src_b_s  = 2'b01;
                pc_write_s   = 1'b1;
                next_state_s = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b_s = 2'b11;
                case (opcode)
                    OP_LW:    next_state_s = S_MEMADR;
                    OP_SW:    next_state_s = S_MEMADR;
                    OP_RTYPE: next_state_s = S_EXEC;
                    OP_BEQ:   next_state_s = S_BEQ;
                    OP_ADDI:  next_state_s = S_ADDIEX;
                    OP_J:     next_state_s = S_JUMP;
                    default:  next_state_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                if (opcode == OP_LW) begin
                    next_state_s = S_MEMRD;
                end else begin
                    next_state_s = S_MEMWR;
                end
            end
            S_MEMRD: begin
                iord_s       = 1'b1;
                next_state_s = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg_s = 1'b1;
                reg_write_s  = 1'b1;
            end
            S_MEMWR: begin
                iord_s      = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_s  = 1'b1;
                alu_op_s     = 2'b10;
                next_state_s = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst_s   = 1'b1;
                reg_write_s = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'b01;
                branch_s    = 1'b1;
                pc_src_s    = 2'b01;
            end
            S_ADDIEX: begin
                alu_src_a_s  = 1'b1;
                alu_src_b_s  = 2'b10;
                next_state_s = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_s = 1'b1;
            end
            S_JUMP: begin
                pc_src_s   = 2'b10;
                pc_write_s = 1'b1;
            end
            default: begin
                next_state_s = S_FETCH;
            end
        endcase
    end

    // Write enables are held off for the whole time rst is high, not just after the edge.
    assign mem_write  = mem_write_s & ~rst;
    assign ir_write   = ir_write_s & ~rst;
    assign reg_write  = reg_write_s & ~rst;
    assign pc_en      = (pc_write_s | (branch_s & zero)) & ~rst;
    assign iord       = iord_s;
    assign reg_dst    = reg_dst_s;
    assign mem_to_reg = mem_to_reg_s;
    assign alu_src_a  = alu_src_a_s;
    assign alu_src_b  = alu_src_b_s;
    assign pc_src     = pc_src_s;
    assign alu_ctrl   = alu_decode(alu_op_s, funct);
    assign state      = state_r;

endmodule
